// File: rtl/threshold_writer_if.sv
// Bundle of the read, write and control signals of threshold_writer.
// master: the threshold writer itself; slave: the memories and the controller around it.
interface threshold_writer_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
);
  logic                   iStart;
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  logic [7:0]             iImageData;
  logic [WIDTH_BITS-1:0]  oMeanCol;
  logic [HEIGHT_BITS-1:0] oMeanRow;
  logic [7:0]             iMeanData;
  logic [WIDTH_BITS-1:0]  oOutCol;
  logic [HEIGHT_BITS-1:0] oOutRow;
  logic [7:0]             oOutData;
  logic                   oOutWren;
  logic                   finished;

  // There is no backpressure: a read address is accepted every cycle and its
  // data returns one cycle later; a write is taken whenever oOutWren is high.
  modport master (
    input  iStart, iImageData, iMeanData,
    output oImageCol, oImageRow, oMeanCol, oMeanRow,
    output oOutCol, oOutRow, oOutData, oOutWren, finished
  );

  modport slave (
    output iStart, iImageData, iMeanData,
    input  oImageCol, oImageRow, oMeanCol, oMeanRow,
    input  oOutCol, oOutRow, oOutData, oOutWren, finished
  );
endinterface

// File: rtl/threshold_writer.sv
// Raster-scans image and local-mean memories and writes a 0x00/0xFF binary frame.
// Define THRESH_INVERT_EN to invert the output polarity (bright where pixel+C <= mean).
module threshold_writer #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int OFFSET      = 2
) (
  input  logic                clock,
  input  logic                reset,
  threshold_writer_if.master  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [WIDTH_BITS-1:0]  COL_LAST = {WIDTH_BITS{1'b1}};
  localparam logic [HEIGHT_BITS-1:0] ROW_LAST = {HEIGHT_BITS{1'b1}};

  state_t                 state_q, state_d;
  logic [WIDTH_BITS-1:0]  col_q, col_d;
  logic [HEIGHT_BITS-1:0] row_q, row_d;
  logic                   vld_q, vld_d;
  logic [WIDTH_BITS-1:0]  tag_col_q, tag_col_d;
  logic [HEIGHT_BITS-1:0] tag_row_q, tag_row_d;
  logic [WIDTH_BITS-1:0]  out_col_q, out_col_d;
  logic [HEIGHT_BITS-1:0] out_row_q, out_row_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_wren_q, out_wren_d;
  logic                   fin_q, fin_d;
  logic                   drain_q, drain_d;

  logic [8:0] biased_sum;
  logic       above_mean;
  logic       pix_on;

  // Nine bits hold pixel + bias without wrap, so 254 + 2 still beats 255.
  assign biased_sum = {1'b0, bus.iImageData} + 9'(OFFSET);
  assign above_mean = biased_sum > {1'b0, bus.iMeanData};

`ifdef THRESH_INVERT_EN
  assign pix_on = ~above_mean;
`else
  assign pix_on = above_mean;
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    vld_d      = 1'b0;
    tag_col_d  = col_q;
    tag_row_d  = row_q;
    out_col_d  = out_col_q;
    out_row_d  = out_row_q;
    out_data_d = out_data_q;
    out_wren_d = vld_q;
    fin_d      = fin_q;
    drain_d    = drain_q;

    // The tag met its returning data this cycle; register the decision.
    if (vld_q) begin
      out_col_d  = tag_col_q;
      out_row_d  = tag_row_q;
      out_data_d = pix_on ? 8'hFF : 8'h00;
    end

    case (state_q)
      IDLE: begin
        if (bus.iStart) state_d = SCAN;
      end
      SCAN: begin
        vld_d   = 1'b1;
        drain_d = 1'b0;
        if (col_q == COL_LAST) begin
          if (row_q == ROW_LAST) begin
            // Counters park on the last pixel instead of wrapping.
            state_d = DRAIN;
          end else begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        fin_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      vld_q      <= 1'b0;
      tag_col_q  <= '0;
      tag_row_q  <= '0;
      out_col_q  <= '0;
      out_row_q  <= '0;
      out_data_q <= 8'h00;
      out_wren_q <= 1'b0;
      fin_q      <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      vld_q      <= vld_d;
      tag_col_q  <= tag_col_d;
      tag_row_q  <= tag_row_d;
      out_col_q  <= out_col_d;
      out_row_q  <= out_row_d;
      out_data_q <= out_data_d;
      out_wren_q <= out_wren_d;
      fin_q      <= fin_d;
      drain_q    <= drain_d;
    end
  end

  assign bus.oImageCol = col_q;
  assign bus.oImageRow = row_q;
  assign bus.oMeanCol  = col_q;
  assign bus.oMeanRow  = row_q;
  assign bus.oOutCol   = out_col_q;
  assign bus.oOutRow   = out_row_q;
  assign bus.oOutData  = out_data_q;
  assign bus.oOutWren  = out_wren_q;
  assign bus.finished  = fin_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_threshold_writer.sv
// Bench for threshold_writer on a 4x4 frame, with bias 2 and bias 0 instances
// scanning the same memories side by side.
module tb_threshold_writer;

  localparam int WB = 2;
  localparam int HB = 2;
  localparam int W  = 1 << WB;
  localparam int N  = 1 << (WB + HB);

`ifdef THRESH_INVERT_EN
  localparam logic [7:0] HI = 8'h00;
  localparam logic [7:0] LO = 8'hFF;
`else
  localparam logic [7:0] HI = 8'hFF;
  localparam logic [7:0] LO = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dbg2, dbg0;

  logic [7:0] img [N];
  logic [7:0] mean_mem [N];

  int checks = 0;
  int errors = 0;

  // timeline model: frame start edge and cycles elapsed since it
  bit armed = 0;
  bit started = 0;
  int t = 0;

  logic [7:0] got [2][N];
  int wr_count [2];
  int first_t [2];
  int fin_t [2];

  threshold_writer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus2 ();
  threshold_writer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus0 ();

  threshold_writer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(2)) u_dut2 (
    .clock(clk), .reset(rst_n), .bus(bus2), .dbg_state(dbg2)
  );
  threshold_writer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(0)) u_dut0 (
    .clock(clk), .reset(rst_n), .bus(bus0), .dbg_state(dbg0)
  );

  always #5 clk = ~clk;

  assign bus2.iStart = start;
  assign bus0.iStart = start;

  // synchronous-read memories, one cycle of latency
  always @(posedge clk) begin
    bus2.iImageData <= img[{bus2.oImageRow, bus2.oImageCol}];
    bus2.iMeanData  <= mean_mem[{bus2.oMeanRow, bus2.oMeanCol}];
    bus0.iImageData <= img[{bus0.oImageRow, bus0.oImageCol}];
    bus0.iMeanData  <= mean_mem[{bus0.oMeanRow, bus0.oMeanCol}];
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        armed = 1;
        started = 0;
        t = 0;
      end else if (!started && start) begin
        started = 1;
        t = 0;
      end else if (started) begin
        t = t + 1;
      end
    end
  end

  function automatic logic [7:0] exp_pix(input int p, input int off);
    int s;
    s = int'(img[p]) + off;
`ifdef THRESH_INVERT_EN
    return (s > int'(mean_mem[p])) ? 8'h00 : 8'hFF;
`else
    return (s > int'(mean_mem[p])) ? 8'hFF : 8'h00;
`endif
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0d actual %0h required %0h", name, id, t, act, exp);
    end
  endtask

  task automatic check_one(input int id, input int off,
                           input logic [WB-1:0] icol, input logic [HB-1:0] irow,
                           input logic [WB-1:0] mcol, input logic [HB-1:0] mrow,
                           input logic [WB-1:0] ocol, input logic [HB-1:0] orow,
                           input logic [7:0] odata, input logic owren, input logic ofin);
    bit exp_wren, exp_fin;
    int p, q;
    exp_wren = started && t >= 2 && t <= N + 1;
    exp_fin  = started && t >= N + 2;
    p = !started ? 0 : (t < N ? t : N - 1);
    if (started && t == 0) begin
      wr_count[id] = 0;
      first_t[id]  = -1;
      fin_t[id]    = -1;
    end
    check("wren", id, 32'(owren), 32'(exp_wren));
    check("finished", id, 32'(ofin), 32'(exp_fin));
    check("img_col", id, 32'(icol), 32'(p % W));
    check("img_row", id, 32'(irow), 32'(p / W));
    check("mean_col", id, 32'(mcol), 32'(p % W));
    check("mean_row", id, 32'(mrow), 32'(p / W));
    if (!started) begin
      check("idle_out_col", id, 32'(ocol), 32'd0);
      check("idle_out_row", id, 32'(orow), 32'd0);
      check("idle_out_data", id, 32'(odata), 32'd0);
    end
    if (exp_wren) begin
      q = t - 2;
      check("out_col", id, 32'(ocol), 32'(q % W));
      check("out_row", id, 32'(orow), 32'(q / W));
      check("out_data", id, 32'(odata), 32'(exp_pix(q, off)));
      got[id][q] = odata;
    end
    if (started && owren === 1'b1) begin
      wr_count[id]++;
      if (first_t[id] < 0) first_t[id] = t;
    end
    if (started && ofin === 1'b1 && fin_t[id] < 0) fin_t[id] = t;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check_one(0, 2, bus2.oImageCol, bus2.oImageRow, bus2.oMeanCol, bus2.oMeanRow,
                  bus2.oOutCol, bus2.oOutRow, bus2.oOutData, bus2.oOutWren, bus2.finished);
        check_one(1, 0, bus0.oImageCol, bus0.oImageRow, bus0.oMeanCol, bus0.oMeanRow,
                  bus0.oOutCol, bus0.oOutRow, bus0.oOutData, bus0.oOutWren, bus0.finished);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    start = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      img[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) mean_mem[i] = 8'($urandom_range(0, 255));
      else mean_mem[i] = 8'((int'(img[i]) + int'($urandom_range(0, 3)) > 255) ? 255
                              : int'(img[i]) + int'($urandom_range(0, 3)));
    end
  endtask

  task automatic run_frame();
    int i;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    i = 0;
    while (i < 100 && !(bus2.finished === 1'b1 && bus0.finished === 1'b1)) begin
      tick(1);
      i++;
    end
    checks++;
    if (i >= 100) begin
      errors++;
      $display("FAIL frame_timeout actual not_finished required finished");
    end
    tick(2);
    for (int id = 0; id < 2; id++) begin
      check("write_count", id, 32'(wr_count[id]), 32'(N));
      check("first_write_t", id, 32'(first_t[id]), 32'd2);
      check("finished_t", id, 32'(fin_t[id]), 32'(N + 2));
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      img[i] = 8'h00;
      mean_mem[i] = 8'h00;
    end

    // reset, then long idle with iStart low
    do_reset(3);
    tick(100);

    // pinned pixels followed by random ones
    load_random();
    img[0] = 8'd97;  mean_mem[0] = 8'd100;
    img[1] = 8'd98;  mean_mem[1] = 8'd100;
    img[2] = 8'd99;  mean_mem[2] = 8'd100;
    img[3] = 8'd254; mean_mem[3] = 8'd255;
    img[4] = 8'd0;   mean_mem[4] = 8'd0;
    run_frame();
    check("pin_97", 0, 32'(got[0][0]), 32'(LO));
    check("pin_98_equal", 0, 32'(got[0][1]), 32'(LO));
    check("pin_99", 0, 32'(got[0][2]), 32'(HI));
    check("pin_254_vs_255", 0, 32'(got[0][3]), 32'(HI));
    check("pin_zero_bias0", 1, 32'(got[1][4]), 32'(LO));

    // DONE must ignore iStart
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      tick(1);
    end
    start = 1'b0;
    check("done_sticky", 0, 32'(bus2.finished), 32'd1);

    // reset while (1,1) is presented, then a full rescan
    do_reset(2);
    tick(3);
    load_random();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 50 && t != 5; i++) tick(1);
    check("abort_point", 0, 32'(t), 32'd5);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    run_frame();

    // a few more random frames with random idle gaps
    for (int f = 0; f < 3; f++) begin
      do_reset(1);
      tick($urandom_range(1, 6));
      load_random();
      run_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/threshold_writer.md
# threshold_writer

Final stage of the adaptive-thresholding pipeline. After the box filter has filled the middle RAM with local means, this block scans the image in raster order. For each pixel it reads the original value from the input ROM and the local mean from the middle RAM, both at the same coordinate. It writes a binary result (0 or 255) to the output RAM and raises `finished` when the whole frame has been written.

## Interface
- `WIDTH_BITS`, 8, column address width; image width = 2^WIDTH_BITS
- `HEIGHT_BITS`, 8, row address width; image height = 2^HEIGHT_BITS
- `OFFSET`, 2, threshold bias C, unsigned 0..255
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `iStart`  in  1  level; connect to box filter `finished`
- `oImageCol` / `oImageRow`  out  WIDTH_BITS / HEIGHT_BITS  input ROM read address
- `iImageData`  in  8  input ROM data, valid 1 cycle after address
- `oMeanCol` / `oMeanRow`  out  WIDTH_BITS / HEIGHT_BITS  middle RAM read address, always equal to image address
- `iMeanData`  in  8  middle RAM data, valid 1 cycle after address
- `oOutCol` / `oOutRow`  out  WIDTH_BITS / HEIGHT_BITS  output RAM write address
- `oOutData`  out  8  0x00 or 0xFF
- `oOutWren`  out  1  output RAM write enable, one cycle per pixel
- `finished`  out  1  sticky frame-complete flag

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - Address outputs are 0.
  - On a clock edge with `iStart`=1, go to SCAN.
- SCAN:
  - Registered counters (col,row) drive both read ports.
  - col increments every cycle; at col = 2^WIDTH_BITS−1 it wraps to 0 and row increments.
  - On the cycle presenting (W−1,H−1), the next state is DRAIN. The counters hold; they do not wrap to (0,0).
- Pipeline:
  - A valid bit and the (col,row) tag follow each address for 1 cycle to meet the returning data.
  - The decision is registered into the `oOut*` outputs.
- Decision:
  - Compute the 9-bit sum `iImageData + OFFSET`. No overflow or underflow is possible.
  - `oOutData` = 0xFF if the sum > `iMeanData`, else 0x00. Equality gives 0x00.
- DRAIN: 2 cycles to flush the pipeline, then DONE.
- DONE:
  - `finished`=1 and addresses hold.
  - `iStart` is ignored; only `reset` leaves DONE.
- Exactly 2^(WIDTH_BITS+HEIGHT_BITS) write pulses per frame, in raster order (row-major, col fastest), with no gaps and no duplicates.
- Reset (`reset`=0) at any time, including mid-SCAN:
  - At that edge, state goes to IDLE and all outputs and the pipeline valid go to 0.
  - In-flight pixels are discarded; no write occurs on the following cycle.

## Timing
- Reset values: all address outputs 0, `oOutData`=0, `oOutWren`=0, `finished`=0.
- Edge E0 samples `iStart`=1 in IDLE. The address for (0,0) is presented in the cycle after E0.
- Read latency: address at cycle k, memory data valid at cycle k+1. The write for that pixel has `oOutWren`=1 at cycle k+2. The address-to-write latency is 2 cycles.
- Throughput is 1 pixel per cycle.
- For N = W·H pixels: writes occur at cycles 2..N+1 after E0, and `finished` rises at cycle N+2 after E0.
- `oOutWren`, `oOutCol`, `oOutRow` and `oOutData` change together and are valid for exactly the cycle in which `oOutWren`=1.
- `finished` never asserts while a write is pending; the last write precedes it by 1 cycle.

## Configuration
- `THRESH_INVERT_EN` defined: the output polarity is inverted. `oOutData` = 0x00 if sum > mean, else 0xFF, so dark features become white.
- `THRESH_INVERT_EN` undefined: the polarity is as described under Operation.
- Timing, write count and addressing are identical in both builds.

## Test plan
- Hold `reset`=0, then release with `iStart`=0 for 100 cycles -> all outputs remain 0, and there are no `oOutWren` pulses.
- Build with `WIDTH_BITS`=`HEIGHT_BITS`=2, then assert `iStart` -> exactly 16 writes in the order (0,0),(1,0)…(3,3).
  - The first write occurs 2 cycles after E0.
  - `finished`=1 exactly 18 cycles after E0 and stays 1 with `iStart` toggling.
- With mean 100 and `OFFSET`=2:
  - pixel 97 -> 0x00
  - pixel 98 -> 0x00 (equality case)
  - pixel 99 -> 0xFF
- Arithmetic extremes:
  - mean 255, pixel 254, `OFFSET`=2 -> 0xFF (9-bit sum 256, no wrap).
  - mean 0, pixel 0, `OFFSET`=0 -> 0x00.
- Reset mid-scan: pulse `reset`=0 for 1 cycle while (1,1) is presented -> no write is issued after the reset edge.
  - Re-assert `iStart` -> rescan from (0,0) with a full 16-write frame.
- Build with `THRESH_INVERT_EN` and rerun the 97/98/99 case -> 0xFF, 0xFF, 0x00, with identical timing.
